rf_bypass_scoreboard: RTL and testbench

Parametrised operand-bypass and RAW-hazard unit for the decode stage, successor to the fixed two-source, three-stage forwarding logic.
- Resolves NUM_SRC source operands against NUM_FWD in-flight pipeline writers, youngest first.
- Stalls when a matching writer's data is not yet produced; this generalises load-use.
- Adds a one-entry scoreboard for a long-latency unit (multiply/divide) with a cycle countdown, result forwarding on completion, flush cancel, and a saturating stall-cycle performance counter.

---
 rtl/rf_bypass_scoreboard.sv | 125 ++++++++++++
 tb/tb_rf_bypass_scoreboard.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_bypass_scoreboard.sv
// Purpose: decode-stage operand bypass with RAW stall detection and a one-entry long-op scoreboard.
// Latency: operands resolve combinationally; long-op result pulses lat_wb max(lat_cycles,1) cycles after issue.
// Backpressure: bypass_stall holds decode; lat_ready low means the issuer must hold lat_issue.
module rf_bypass_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      id_valid,
  input  logic [NUM_SRC*5-1:0]      id_src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] rf_src_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*5-1:0]      fwd_addr,
  input  logic [NUM_FWD-1:0]        fwd_data_ok,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      lat_issue,
  input  logic [4:0]                lat_addr,
  input  logic [CNT_W-1:0]          lat_cycles,
  input  logic [DATA_W-1:0]         lat_data,
  input  logic                      flush,
  input  logic                      perf_clr,
  output logic [NUM_SRC*DATA_W-1:0] src_data_out,
  output logic                      bypass_stall,
  output logic                      lat_ready,
  output logic                      lat_wb,
  output logic [PERF_W-1:0]         stall_cnt
);

  // Long-op scoreboard state: one pending destination with a countdown.
  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       pend_addr;
  logic             lat_accept;
  logic [CNT_W-1:0] cnt_start;
  logic [NUM_SRC-1:0] slot_stall;

  assign lat_wb    = busy && (cnt == CNT_W'(1));
  assign lat_ready = !busy || lat_wb;
  // A flush kills only the older pending op, so an issue alongside it still lands.
  assign lat_accept = lat_issue && (lat_ready || flush);
  // Zero latency is treated as one so the result always appears in a later cycle.
  assign cnt_start  = (lat_cycles == '0) ? CNT_W'(1) : lat_cycles;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    logic [4:0]        src;
    logic              hit;
    logic              hit_ok;
    logic [DATA_W-1:0] hit_data;
    logic [DATA_W-1:0] opnd;
    logic              stall_req;

    assign src = id_src_addr[5*i +: 5];

    // Find the youngest in-flight writer of this source; scanning oldest-first lets younger hits override.
    always_comb begin
      hit      = 1'b0;
      hit_ok   = 1'b0;
      hit_data = '0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_valid[k] && (fwd_addr[5*k +: 5] == src) && (fwd_addr[5*k +: 5] != 5'd0)) begin
          hit      = 1'b1;
          hit_ok   = fwd_data_ok[k];
          hit_data = fwd_data[DATA_W*k +: DATA_W];
        end
      end
    end

    // Pick the operand source: r0, pipeline writer, pending long op, then register file.
    always_comb begin
      opnd      = rf_src_data[DATA_W*i +: DATA_W];
      stall_req = 1'b0;
      if (src == 5'd0) begin
        opnd = '0;
      end else if (hit) begin
        opnd      = hit_data;
        stall_req = !hit_ok;
      end else if (busy && (pend_addr == src)) begin
        if (lat_wb) begin
          opnd = lat_data;
        end else begin
          stall_req = 1'b1;
        end
      end
    end

    assign src_data_out[DATA_W*i +: DATA_W] = opnd;
    assign slot_stall[i] = stall_req;
  end

  assign bypass_stall = id_valid && (|slot_stall);

  // Scoreboard update: new issue beats flush and completion; otherwise count down.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy      <= 1'b0;
      cnt       <= '0;
      pend_addr <= '0;
    end else if (lat_accept) begin
      busy      <= 1'b1;
      cnt       <= cnt_start;
      pend_addr <= lat_addr;
    end else if (flush || lat_wb) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Saturating count of stalled decode cycles; clear has priority.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (perf_clr) begin
      stall_cnt <= '0;
    end else if (bypass_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_bypass_scoreboard.sv
// Purpose: self-checking bench for rf_bypass_scoreboard, directed scenarios plus random traffic vs a reference model.
// Latency: inputs change on the falling edge, outputs are sampled 1ns later.
// Backpressure: the model tracks lat_ready/flush acceptance independently of the design.
module tb_rf_bypass_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [9:0]  id_src_addr;
  logic [63:0] rf_src_data;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_addr;
  logic [2:0]  fwd_data_ok;
  logic [95:0] fwd_data;
  logic        lat_issue;
  logic [4:0]  lat_addr;
  logic [5:0]  lat_cycles;
  logic [31:0] lat_data;
  logic        flush;
  logic        perf_clr;
  logic [63:0] src_data_out;
  logic        bypass_stall;
  logic        lat_ready;
  logic        lat_wb;
  logic [7:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  rf_bypass_scoreboard #(.DATA_W(32), .NUM_SRC(2), .NUM_FWD(3), .CNT_W(6), .PERF_W(8)) dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .rf_src_data(rf_src_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data_ok(fwd_data_ok), .fwd_data(fwd_data), .lat_issue(lat_issue),
    .lat_addr(lat_addr), .lat_cycles(lat_cycles), .lat_data(lat_data), .flush(flush),
    .perf_clr(perf_clr), .src_data_out(src_data_out), .bypass_stall(bypass_stall),
    .lat_ready(lat_ready), .lat_wb(lat_wb), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the pending long op is kept as an absolute completion cycle.
  int         cyc    = 0;
  bit         m_busy = 1'b0;
  int         m_done = 0;
  logic [4:0] m_addr = 5'd0;
  logic [7:0] m_cnt  = 8'd0;

  function automatic bit m_wb();
    return m_busy && (cyc == m_done);
  endfunction

  function automatic void m_slot(input int i, output logic [31:0] d, output bit st);
    logic [4:0] s;
    s  = id_src_addr[5*i +: 5];
    d  = rf_src_data[32*i +: 32];
    st = 1'b0;
    if (s == 5'd0) begin
      d = 32'd0;
      return;
    end
    for (int k = 0; k < 3; k++) begin
      if (fwd_valid[k] && fwd_addr[5*k +: 5] == s) begin
        d  = fwd_data[32*k +: 32];
        st = !fwd_data_ok[k];
        return;
      end
    end
    if (m_busy && m_addr == s) begin
      if (m_wb()) d = lat_data;
      else st = 1'b1;
    end
  endfunction

  function automatic bit m_stall();
    logic [31:0] d;
    bit s0, s1;
    m_slot(0, d, s0);
    m_slot(1, d, s1);
    return id_valid && (s0 || s1);
  endfunction

  always @(posedge clk or negedge resetn) begin : model_upd
    bit st, wb, rdy;
    int lc;
    if (!resetn) begin
      m_busy = 1'b0;
      m_done = 0;
      m_addr = 5'd0;
      m_cnt  = 8'd0;
    end else begin
      st  = m_stall();
      wb  = m_wb();
      rdy = !m_busy || wb;
      lc  = (lat_cycles == 6'd0) ? 1 : int'(lat_cycles);
      if (perf_clr) m_cnt = 8'd0;
      else if (st && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (lat_issue && (rdy || flush)) begin
        m_busy = 1'b1;
        m_addr = lat_addr;
        m_done = cyc + lc;
      end else if (flush || wb) begin
        m_busy = 1'b0;
      end
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before 400000");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    id_valid    = 1'b0;
    id_src_addr = '0;
    rf_src_data = {32'hCAFE_0001, 32'hCAFE_0000};
    fwd_valid   = '0;
    fwd_addr    = '0;
    fwd_data_ok = '0;
    fwd_data    = '0;
    lat_issue   = 1'b0;
    lat_addr    = '0;
    lat_cycles  = '0;
    lat_data    = '0;
    flush       = 1'b0;
    perf_clr    = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    #3;
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0h exp=0", stall_cnt); end
    checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL reset_lat_ready got=%0b exp=1", lat_ready); end
    checks++; if (lat_wb !== 1'b0) begin errors++; $display("FAIL reset_lat_wb got=%0b exp=0", lat_wb); end
    checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bypass_stall); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    idle();
    id_valid    = 1'b1;
    id_src_addr = {5'd0, 5'd5};
    fwd_valid   = 3'b111;
    fwd_addr    = {5'd5, 5'd5, 5'd5};
    fwd_data_ok = 3'b111;
    fwd_data    = {32'h33, 32'h22, 32'h11};
    #1;
    checks++; if (src_data_out[31:0] !== 32'h11) begin errors++; $display("FAIL fwd_ex got=%h exp=11", src_data_out[31:0]); end
    checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL fwd_ex_stall got=%0b exp=0", bypass_stall); end
    checks++; if (src_data_out[63:32] !== 32'd0) begin errors++; $display("FAIL fwd_r0_slot1 got=%h exp=0", src_data_out[63:32]); end
    fwd_valid = 3'b110;
    #1;
    checks++; if (src_data_out[31:0] !== 32'h22) begin errors++; $display("FAIL fwd_mem got=%h exp=22", src_data_out[31:0]); end
    fwd_valid = 3'b100;
    #1;
    checks++; if (src_data_out[31:0] !== 32'h33) begin errors++; $display("FAIL fwd_wb got=%h exp=33", src_data_out[31:0]); end
    fwd_valid = 3'b000;
    #1;
    checks++; if (src_data_out[31:0] !== 32'hCAFE_0000) begin errors++; $display("FAIL fwd_rf got=%h exp=cafe0000", src_data_out[31:0]); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    id_valid    = 1'b1;
    id_src_addr = {5'd7, 5'd0};
    fwd_valid   = 3'b011;
    fwd_addr    = {5'd0, 5'd7, 5'd7};
    fwd_data_ok = 3'b010;
    fwd_data    = {32'h0, 32'h55, 32'h0};
    #1;
    checks++; if (bypass_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got=%0b exp=1", bypass_stall); end
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL loaduse_cnt0 got=%0d exp=0", stall_cnt); end
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      #1;
      checks++; if (stall_cnt !== 8'(j)) begin errors++; $display("FAIL loaduse_cnt got=%0d exp=%0d", stall_cnt, j); end
    end
    fwd_data_ok = 3'b011;
    fwd_data    = {32'h0, 32'h55, 32'hABCD};
    #1;
    checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL loaduse_clear got=%0b exp=0", bypass_stall); end
    checks++; if (src_data_out[63:32] !== 32'hABCD) begin errors++; $display("FAIL loaduse_data got=%h exp=abcd", src_data_out[63:32]); end
    @(negedge clk);
    #1;
    checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL loaduse_cnt_hold got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_long_op();
    @(negedge clk);
    idle();
    lat_issue  = 1'b1;
    lat_addr   = 5'd9;
    lat_cycles = 6'd4;
    #1;
    checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL long_ready_idle got=%0b exp=1", lat_ready); end
    @(negedge clk);
    lat_issue   = 1'b0;
    id_valid    = 1'b1;
    id_src_addr = {5'd0, 5'd9};
    lat_data    = 32'hDEAD;
    rf_src_data = {32'h0, 32'h1234};
    for (int j = 1; j <= 4; j++) begin
      #1;
      if (j < 4) begin
        checks++; if (bypass_stall !== 1'b1) begin errors++; $display("FAIL long_stall c%0d got=%0b exp=1", j, bypass_stall); end
        checks++; if (lat_ready !== 1'b0) begin errors++; $display("FAIL long_ready c%0d got=%0b exp=0", j, lat_ready); end
        checks++; if (lat_wb !== 1'b0) begin errors++; $display("FAIL long_wb c%0d got=%0b exp=0", j, lat_wb); end
      end else begin
        checks++; if (lat_wb !== 1'b1) begin errors++; $display("FAIL long_wb_done got=%0b exp=1", lat_wb); end
        checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL long_stall_done got=%0b exp=0", bypass_stall); end
        checks++; if (src_data_out[31:0] !== 32'hDEAD) begin errors++; $display("FAIL long_fwd got=%h exp=dead", src_data_out[31:0]); end
        checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL long_ready_done got=%0b exp=1", lat_ready); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (lat_wb !== 1'b0) begin errors++; $display("FAIL long_wb_after got=%0b exp=0", lat_wb); end
    checks++; if (src_data_out[31:0] !== 32'h1234) begin errors++; $display("FAIL long_rf_after got=%h exp=1234", src_data_out[31:0]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    idle();
    lat_issue  = 1'b1;
    lat_addr   = 5'd4;
    lat_cycles = 6'd3;
    @(negedge clk);
    lat_issue = 1'b0;
    @(negedge clk);
    @(negedge clk);
    lat_issue  = 1'b1;
    lat_addr   = 5'd6;
    lat_cycles = 6'd2;
    #1;
    checks++; if (lat_wb !== 1'b1) begin errors++; $display("FAIL b2b_wb1 got=%0b exp=1", lat_wb); end
    checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b exp=1", lat_ready); end
    @(negedge clk);
    lat_issue   = 1'b0;
    id_valid    = 1'b1;
    id_src_addr = {5'd4, 5'd6};
    lat_data    = 32'h6666;
    rf_src_data = {32'h4444_0000, 32'h6666_0000};
    #1;
    checks++; if (bypass_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got=%0b exp=1", bypass_stall); end
    checks++; if (lat_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy got=%0b exp=0", lat_ready); end
    checks++; if (src_data_out[63:32] !== 32'h4444_0000) begin errors++; $display("FAIL b2b_old_dest got=%h exp=44440000", src_data_out[63:32]); end
    @(negedge clk);
    #1;
    checks++; if (lat_wb !== 1'b1) begin errors++; $display("FAIL b2b_wb2 got=%0b exp=1", lat_wb); end
    checks++; if (src_data_out[31:0] !== 32'h6666) begin errors++; $display("FAIL b2b_fwd got=%h exp=6666", src_data_out[31:0]); end
    lat_issue  = 1'b1;
    lat_addr   = 5'd6;
    lat_cycles = 6'd0;
    @(negedge clk);
    lat_issue = 1'b0;
    lat_data  = 32'h0ACE;
    #1;
    checks++; if (lat_wb !== 1'b1) begin errors++; $display("FAIL zero_lat_wb got=%0b exp=1", lat_wb); end
    checks++; if (src_data_out[31:0] !== 32'h0ACE) begin errors++; $display("FAIL zero_lat_fwd got=%h exp=ace", src_data_out[31:0]); end
    @(negedge clk);
    #1;
    checks++; if (lat_wb !== 1'b0) begin errors++; $display("FAIL zero_lat_after got=%0b exp=0", lat_wb); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle();
    lat_issue  = 1'b1;
    lat_addr   = 5'd3;
    lat_cycles = 6'd5;
    @(negedge clk);
    lat_issue   = 1'b0;
    id_valid    = 1'b1;
    id_src_addr = {5'd10, 5'd3};
    rf_src_data = {32'h1010, 32'h3333};
    #1;
    checks++; if (bypass_stall !== 1'b1) begin errors++; $display("FAIL flush_pre_stall got=%0b exp=1", bypass_stall); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", bypass_stall); end
    checks++; if (src_data_out[31:0] !== 32'h3333) begin errors++; $display("FAIL flush_rf got=%h exp=3333", src_data_out[31:0]); end
    checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", lat_ready); end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      checks++; if (lat_wb !== 1'b0) begin errors++; $display("FAIL flush_no_wb c%0d got=%0b exp=0", j, lat_wb); end
    end
    lat_issue  = 1'b1;
    lat_addr   = 5'd10;
    lat_cycles = 6'd6;
    @(negedge clk);
    lat_addr   = 5'd11;
    lat_cycles = 6'd2;
    flush      = 1'b1;
    #1;
    checks++; if (lat_ready !== 1'b0) begin errors++; $display("FAIL flushiss_ready got=%0b exp=0", lat_ready); end
    @(negedge clk);
    lat_issue   = 1'b0;
    flush       = 1'b0;
    id_src_addr = {5'd10, 5'd11};
    lat_data    = 32'hB0B0;
    #1;
    checks++; if (bypass_stall !== 1'b1) begin errors++; $display("FAIL flushiss_stall got=%0b exp=1", bypass_stall); end
    checks++; if (src_data_out[63:32] !== 32'h1010) begin errors++; $display("FAIL flushiss_old got=%h exp=1010", src_data_out[63:32]); end
    @(negedge clk);
    #1;
    checks++; if (lat_wb !== 1'b1) begin errors++; $display("FAIL flushiss_wb got=%0b exp=1", lat_wb); end
    checks++; if (src_data_out[31:0] !== 32'hB0B0) begin errors++; $display("FAIL flushiss_fwd got=%h exp=b0b0", src_data_out[31:0]); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    idle();
    lat_issue  = 1'b1;
    lat_addr   = 5'd12;
    lat_cycles = 6'd10;
    @(negedge clk);
    lat_issue   = 1'b0;
    id_valid    = 1'b1;
    id_src_addr = {5'd0, 5'd12};
    rf_src_data = {32'h0, 32'h1212};
    @(negedge clk);
    @(negedge clk);
    #2;
    checks++; if (stall_cnt === 8'd0) begin errors++; $display("FAIL areset_pre_cnt got=%0d exp=nonzero", stall_cnt); end
    resetn = 1'b0;
    #1;
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL areset_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%0b exp=1", lat_ready); end
    checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL areset_stall got=%0b exp=0", bypass_stall); end
    checks++; if (src_data_out[31:0] !== 32'h1212) begin errors++; $display("FAIL areset_rf got=%h exp=1212", src_data_out[31:0]); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_r0_and_perf();
    @(negedge clk);
    idle();
    lat_issue  = 1'b1;
    lat_addr   = 5'd0;
    lat_cycles = 6'd3;
    @(negedge clk);
    lat_issue   = 1'b0;
    id_valid    = 1'b1;
    id_src_addr = {5'd0, 5'd0};
    rf_src_data = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    fwd_valid   = 3'b111;
    fwd_addr    = '0;
    fwd_data_ok = 3'b000;
    fwd_data    = {96{1'b1}};
    #1;
    checks++; if (lat_ready !== 1'b0) begin errors++; $display("FAIL r0_issue_busy got=%0b exp=0", lat_ready); end
    checks++; if (src_data_out !== 64'd0) begin errors++; $display("FAIL r0_operand got=%h exp=0", src_data_out); end
    checks++; if (bypass_stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%0b exp=0", bypass_stall); end
    perf_clr    = 1'b1;
    @(negedge clk);
    perf_clr    = 1'b0;
    id_src_addr = {5'd0, 5'd7};
    fwd_addr    = {5'd0, 5'd0, 5'd7};
    for (int j = 0; j < 300; j++) @(negedge clk);
    #1;
    checks++; if (stall_cnt !== 8'hFF) begin errors++; $display("FAIL perf_sat got=%0h exp=ff", stall_cnt); end
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    #1;
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL perf_clr got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    #1;
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL perf_restart got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] d0, d1;
    bit s0, s1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      id_valid    = ($urandom_range(0, 3) != 0);
      id_src_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_src_data = {$urandom, $urandom};
      fwd_valid   = 3'($urandom);
      fwd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data_ok = 3'($urandom) | 3'($urandom);
      fwd_data    = {$urandom, $urandom, $urandom};
      lat_issue   = ($urandom_range(0, 3) == 0);
      lat_addr    = 5'($urandom_range(0, 7));
      lat_cycles  = 6'($urandom_range(0, 5));
      lat_data    = $urandom;
      flush       = ($urandom_range(0, 19) == 0);
      perf_clr    = ($urandom_range(0, 39) == 0);
      #1;
      m_slot(0, d0, s0);
      m_slot(1, d1, s1);
      checks++; if (lat_wb !== m_wb()) begin errors++; $display("FAIL rnd_wb n=%0d got=%0b exp=%0b", n, lat_wb, m_wb()); end
      checks++; if (lat_ready !== (!m_busy || m_wb())) begin errors++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, lat_ready, !m_busy || m_wb()); end
      checks++; if (bypass_stall !== (id_valid && (s0 || s1))) begin errors++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, bypass_stall, id_valid && (s0 || s1)); end
      checks++; if (stall_cnt !== m_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_cnt); end
      if (!s0) begin
        checks++; if (src_data_out[31:0] !== d0) begin errors++; $display("FAIL rnd_slot0 n=%0d got=%h exp=%h", n, src_data_out[31:0], d0); end
      end
      if (!s1) begin
        checks++; if (src_data_out[63:32] !== d1) begin errors++; $display("FAIL rnd_slot1 n=%0d got=%h exp=%h", n, src_data_out[63:32], d1); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_long_op();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_r0_and_perf();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
